// File: rtl/div_pkg.sv
// Shared FSM type, default sizing and helpers for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } divState_t;

  // Widest operand the abs helper handles; callers truncate back to their width.
  localparam int MAX_W = 64;

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Truncating the result to w bits yields the w-bit two's-complement magnitude.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEPS = 1;
  localparam int DEF_CNT_W = cntWidth(DEF_WIDTH / DEF_STEPS);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract divisor.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor on entry, so shifted < 2*divisor and trial[WIDTH] is a clean borrow.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};
  assign rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider: WIDTH/STEPS_PER_CYCLE RUN cycles plus one FIXUP; done pulses N+2 cycles after start.
// start is ignored while busy; kill aborts without a done pulse and leaves the previous results in place.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int STEPS_PER_CYCLE = DEF_STEPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic             kill,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int N     = WIDTH / STEPS_PER_CYCLE;
  localparam int CNT_W = cntWidth(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  divState_t        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] remR;
  logic [WIDTH-1:0] quoR;
  logic [WIDTH-1:0] divR;
  logic             signQ;
  logic             signR;
  logic             dbzR;
  logic             ovfR;

  logic             signA;
  logic             signB;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic             isZero;
  logic             isOvf;

  assign signA  = signed_op & dividend[WIDTH-1];
  assign signB  = signed_op & divisor[WIDTH-1];
  assign absA   = WIDTH'(abs_w(MAX_W'(dividend), signA));
  assign absB   = WIDTH'(abs_w(MAX_W'(divisor), signB));
  assign isZero = (divisor == '0);
  assign isOvf  = signed_op && (dividend == MIN_NEG) && (divisor == '1);

  assign busy = (state != IDLE);

  logic [WIDTH-1:0] remChain [STEPS_PER_CYCLE+1];
  logic [WIDTH-1:0] quoChain [STEPS_PER_CYCLE+1];

  assign remChain[0] = remR;
  assign quoChain[0] = quoR;

  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : gStep
    div_step #(
      .WIDTH(WIDTH)
    ) uStep (
      .rem     (remChain[g]),
      .quo     (quoChain[g]),
      .divisor (divR),
      .rem_nxt (remChain[g+1]),
      .quo_nxt (quoChain[g+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      remR        <= '0;
      quoR        <= '0;
      divR        <= '0;
      signQ       <= 1'b0;
      signR       <= 1'b0;
      dbzR        <= 1'b0;
      ovfR        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !kill) begin
            divR  <= absB;
            signQ <= signA ^ signB;
            signR <= signA;
            cnt   <= '0;
            dbzR  <= isZero;
            ovfR  <= isOvf && !isZero;
            // Special cases preload the final magnitudes and go straight to FIXUP.
            if (isZero) begin
              remR  <= absA;
              quoR  <= '1;
              state <= FIXUP;
            end else if (isOvf) begin
              remR  <= '0;
              quoR  <= absA;
              state <= FIXUP;
            end else begin
              remR  <= '0;
              quoR  <= absA;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            remR <= remChain[STEPS_PER_CYCLE];
            quoR <= quoChain[STEPS_PER_CYCLE];
            cnt  <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) state <= FIXUP;
          end
        end
        FIXUP: begin
          state <= IDLE;
          if (!kill) begin
            done        <= 1'b1;
            quotient    <= dbzR ? '1 : (signQ ? -quoR : quoR);
            remainder   <= signR ? -remR : remR;
            div_by_zero <= dbzR;
            overflow    <= ovfR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: one radix-2 instance and one 4-steps-per-cycle instance.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic        kill = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] quotient, remainder;

  logic        start4 = 1'b0;
  logic [31:0] dividend4 = '0;
  logic [31:0] divisor4 = '0;
  logic        busy4, done4, dbz4, ovf4;
  logic [31:0] quotient4, remainder4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(32), .STEPS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op), .kill(kill),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  div_iter #(.WIDTH(32), .STEPS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_op(1'b0), .kill(1'b0),
    .dividend(dividend4), .divisor(divisor4), .busy(busy4), .done(done4),
    .quotient(quotient4), .remainder(remainder4), .div_by_zero(dbz4), .overflow(ovf4)
  );

  // Drives start for one cycle (cycle 0); returns at the negedge of cycle 1.
  task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_op = sg;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the cycle number in which done is seen, or -1 if it never arrives.
  task automatic waitDone(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({busy, done, div_by_zero, overflow, quotient, remainder} !== 68'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b dbz=%b ovf=%b q=%h r=%h exp all zero",
               busy, done, div_by_zero, overflow, quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_unsigned;
    int cyc;
    int busyBad;
    launch(1'b0, 32'd100, 32'd7);
    busyBad = 0;
    cyc = 1;
    while (cyc <= 33) begin
      if (busy !== 1'b1 || done !== 1'b0) busyBad++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (busyBad != 0) begin
      bad++;
      $display("FAIL busy_window got %0d bad cycles in 1..33 exp 0", busyBad);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_cycle34 got done=%b busy=%b exp 1 0", done, busy);
    end
    total++;
    if (quotient !== 32'd14 || remainder !== 32'd2) begin
      bad++;
      $display("FAIL u100_7 got q=%0d r=%0d exp q=14 r=2", quotient, remainder);
    end
    total++;
    if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL u100_7_flags got dbz=%b ovf=%b exp 0 0", div_by_zero, overflow);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width got done=%b exp 0", done);
    end
    launch(1'b0, 32'hFFFFFFFF, 32'd1);
    waitDone(1, cyc);
    total++;
    if (cyc != 34 || quotient !== 32'hFFFFFFFF || remainder !== 32'd0) begin
      bad++;
      $display("FAIL umax_1 got cyc=%0d q=%h r=%h exp 34 ffffffff 0", cyc, quotient, remainder);
    end
    launch(1'b0, 32'h80000000, 32'hFFFFFFFF);
    waitDone(1, cyc);
    total++;
    if (cyc != 34 || quotient !== 32'd0 || remainder !== 32'h80000000 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL umin_allones got cyc=%0d q=%h r=%h ovf=%b exp 34 0 80000000 0",
               cyc, quotient, remainder, overflow);
    end
  endtask

  task automatic test_signed;
    int cyc;
    launch(1'b1, 32'hFFFFFFF9, 32'd2);
    waitDone(1, cyc);
    total++;
    if (cyc != 34 || quotient !== 32'hFFFFFFFD || remainder !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL s_m7_2 got cyc=%0d q=%h r=%h exp 34 fffffffd ffffffff", cyc, quotient, remainder);
    end
    launch(1'b1, 32'd7, 32'hFFFFFFFE);
    waitDone(1, cyc);
    total++;
    if (quotient !== 32'hFFFFFFFD || remainder !== 32'd1) begin
      bad++;
      $display("FAIL s_7_m2 got q=%h r=%h exp fffffffd 00000001", quotient, remainder);
    end
  endtask

  task automatic test_special;
    int cyc;
    launch(1'b1, 32'h80000000, 32'hFFFFFFFF);
    waitDone(1, cyc);
    total++;
    if (cyc != 2 || quotient !== 32'h80000000 || remainder !== 32'd0 ||
        overflow !== 1'b1 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL s_overflow got cyc=%0d q=%h r=%h ovf=%b dbz=%b exp 2 80000000 0 1 0",
               cyc, quotient, remainder, overflow, div_by_zero);
    end
    launch(1'b0, 32'd12345, 32'd0);
    waitDone(1, cyc);
    total++;
    if (cyc != 2 || quotient !== 32'hFFFFFFFF || remainder !== 32'd12345 ||
        div_by_zero !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL u_div0 got cyc=%0d q=%h r=%0d dbz=%b ovf=%b exp 2 ffffffff 12345 1 0",
               cyc, quotient, remainder, div_by_zero, overflow);
    end
    launch(1'b1, 32'hFFFFFFFB, 32'd0);
    waitDone(1, cyc);
    total++;
    if (quotient !== 32'hFFFFFFFF || remainder !== 32'hFFFFFFFB || div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL s_div0 got q=%h r=%h dbz=%b exp ffffffff fffffffb 1", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_busy_start;
    int cyc;
    launch(1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    signed_op = 1'b1;
    dividend  = 32'd9;
    divisor   = 32'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(6, cyc);
    total++;
    if (cyc != 34 || quotient !== 32'd14 || remainder !== 32'd2) begin
      bad++;
      $display("FAIL start_while_busy got cyc=%0d q=%0d r=%0d exp 34 14 2", cyc, quotient, remainder);
    end
  endtask

  task automatic test_kill;
    int cyc;
    int doneSeen;
    launch(1'b0, 32'd1000, 32'd10);
    waitDone(1, cyc);
    launch(1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL kill_idle got busy=%b done=%b exp 0 0", busy, done);
    end
    doneSeen = 0;
    repeat (40) begin
      if (done === 1'b1) doneSeen++;
      @(negedge clk);
    end
    total++;
    if (doneSeen != 0 || quotient !== 32'd100 || remainder !== 32'd0) begin
      bad++;
      $display("FAIL kill_hold got dones=%0d q=%0d r=%0d exp 0 100 0", doneSeen, quotient, remainder);
    end
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    kill     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    kill  = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL kill_beats_start got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    launch(1'b0, 32'd100, 32'd7);
    waitDone(1, cyc);
    total++;
    if (quotient !== 32'd14 || remainder !== 32'd2) begin
      bad++;
      $display("FAIL b2b_first got q=%0d r=%0d exp 14 2", quotient, remainder);
    end
    signed_op = 1'b1;
    dividend  = 32'hFFFFFFF9;
    divisor   = 32'd2;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(1, cyc);
    total++;
    if (cyc != 34 || quotient !== 32'hFFFFFFFD || remainder !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL b2b_second got cyc=%0d q=%h r=%h exp 34 fffffffd ffffffff", cyc, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    launch(1'b0, 32'd5, 32'd0);
    waitDone(1, cyc);
    launch(1'b0, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, div_by_zero, overflow, quotient, remainder} !== 68'd0) begin
      bad++;
      $display("FAIL reset_mid got busy=%b done=%b dbz=%b ovf=%b q=%h r=%h exp all zero",
               busy, done, div_by_zero, overflow, quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_steps4;
    int cyc;
    @(negedge clk);
    dividend4 = 32'd1000;
    divisor4  = 32'd33;
    start4    = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cyc = 1;
    while (done4 !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc != 10 || quotient4 !== 32'd30 || remainder4 !== 32'd10) begin
      bad++;
      $display("FAIL steps4_1000_33 got cyc=%0d q=%0d r=%0d exp 10 30 10", cyc, quotient4, remainder4);
    end
  endtask

  task automatic test_random;
    int cyc;
    int sa;
    int sb;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] qe;
    logic [31:0] re;
    logic sg;
    for (int i = 0; i < 12; i++) begin
      a  = $urandom;
      b  = $urandom;
      if (i % 3 == 0) b = b >> $urandom_range(31, 8);
      sg = i[0];
      if (b == 32'd0) b = 32'd1;
      if (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      if (sg) begin
        sa = a;
        sb = b;
        qe = sa / sb;
        re = sa % sb;
      end else begin
        qe = a / b;
        re = a % b;
      end
      launch(sg, a, b);
      waitDone(1, cyc);
      total++;
      if (cyc != 34 || quotient !== qe || remainder !== re) begin
        bad++;
        $display("FAIL random_%0d got cyc=%0d q=%h r=%h exp 34 q=%h r=%h (s=%b a=%h b=%h)",
                 i, cyc, quotient, remainder, qe, re, sg, a, b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_busy_start();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    test_steps4();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
